mdu: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage, sitting beside the single-cycle ALU. Execute issues any M-extension operation with a one-cycle start pulse; the unit stalls the pipeline through `o_busy` and returns one 32-bit result with a `o_done` pulse. Multiply uses radix-2 shift-add and divide uses restoring division, each at one bit per cycle. Divide-by-zero and signed overflow complete early.

---
 rtl/mdu_pkg.sv | 34 +++
 rtl/mdu_divstep.sv | 22 ++
 rtl/mdu.sv | 142 ++++++++++++++
 tb/tb_mdu.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
// XLEN defaults to 32 unless the build already defines it.
`ifndef XLEN
`define XLEN 32
`endif

package mdu_pkg;

   localparam int XLEN      = `XLEN;
   localparam int MDU_ITERS = 32;

   localparam logic [XLEN-1:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
   localparam logic [XLEN-1:0] DIV_OVF_Q  = 32'h8000_0000;

   typedef enum logic [2:0] {
      OP_MUL    = 3'd0,
      OP_MULH   = 3'd1,
      OP_MULHSU = 3'd2,
      OP_MULHU  = 3'd3,
      OP_DIV    = 3'd4,
      OP_DIVU   = 3'd5,
      OP_REM    = 3'd6,
      OP_REMU   = 3'd7
   } mdu_op_e;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_MUL_IT = 3'd1,
      S_DIV_IT = 3'd2,
      S_FIX    = 3'd3,
      S_DONE   = 3'd4
   } mdu_state_e;

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: shift in the next dividend bit and subtract
// the divisor when that does not borrow.
module mdu_divstep
   import mdu_pkg::*;
(
   input  logic [XLEN:0]   i_rem,
   input  logic            i_bit,
   input  logic [XLEN-1:0] i_divisor,
   output logic [XLEN:0]   o_rem,
   output logic            o_qbit
);

   logic [XLEN:0]   w_shift;
   logic [XLEN+1:0] w_diff;

   assign w_shift = {i_rem[XLEN-1:0], i_bit};
   assign w_diff  = {1'b0, w_shift} - {2'b00, i_divisor};
   // A set top bit would make the shifted value exceed any divisor.
   assign o_qbit  = ~w_diff[XLEN+1] | i_rem[XLEN];
   assign o_rem   = o_qbit ? w_diff[XLEN:0] : w_shift;

endmodule

// File: rtl/mdu.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring
// divide at one bit per cycle, with early completion for special divides.
module mdu
   import mdu_pkg::*;
(
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_start,
   input  logic [2:0]      i_op,
   input  logic [XLEN-1:0] i_Ra,
   input  logic [XLEN-1:0] i_Rb,
   input  logic            i_kill,
   output logic            o_busy,
   output logic            o_done,
   output logic [XLEN-1:0] o_result
);

   mdu_state_e          r_state, w_next;
   mdu_op_e             r_op, w_op;
   logic [4:0]          r_cnt;
   logic [XLEN-1:0]     r_result;
   logic                r_neg_res, r_neg_rem;
   logic [2*XLEN-1:0]   r_acc, r_mcand;
   logic [XLEN-1:0]     r_mplier, r_dvd, r_dvs;
   logic [XLEN:0]       r_rem;

   logic                w_accept, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
   logic                w_div0, w_ovf, w_special, w_iter;
   logic [XLEN-1:0]     w_abs_a, w_abs_b, w_spec_res, w_fix_res;
   logic [XLEN:0]       w_step_rem;
   logic                w_qbit;
   logic [2*XLEN-1:0]   w_prod;

   function automatic logic [XLEN-1:0] fix32(input logic [XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   function automatic logic [2*XLEN-1:0] fix64(input logic [2*XLEN-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction

   assign w_op     = mdu_op_e'(i_op);
   assign w_sgn_a  = (w_op == OP_MULH) || (w_op == OP_MULHSU) || (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_sgn_b  = (w_op == OP_MULH) || (w_op == OP_DIV) || (w_op == OP_REM);
   assign w_neg_a  = w_sgn_a & i_Ra[XLEN-1];
   assign w_neg_b  = w_sgn_b & i_Rb[XLEN-1];
   assign w_abs_a  = fix32(i_Ra, w_neg_a);
   assign w_abs_b  = fix32(i_Rb, w_neg_b);

   assign w_div0    = i_op[2] && (i_Rb == '0);
   assign w_ovf     = ((w_op == OP_DIV) || (w_op == OP_REM)) && (i_Ra == DIV_OVF_Q) && (i_Rb == '1);
   assign w_special = w_div0 || w_ovf;
   // i_op[1] separates REM/REMU from DIV/DIVU within the divide group.
   assign w_spec_res = w_div0 ? (i_op[1] ? i_Ra : DIV_ZERO_Q)
                              : (i_op[1] ? '0   : DIV_OVF_Q);

   assign w_accept = ((r_state == S_IDLE) || (r_state == S_DONE)) && i_start && !i_kill;
   assign w_iter   = (r_state == S_MUL_IT) || (r_state == S_DIV_IT);

   mdu_divstep u_divstep (
      .i_rem     (r_rem),
      .i_bit     (r_dvd[XLEN-1]),
      .i_divisor (r_dvs),
      .o_rem     (w_step_rem),
      .o_qbit    (w_qbit)
   );

   assign w_prod = fix64(r_acc, r_neg_res);

   always_comb begin
      w_fix_res = '0;
      case (r_op)
         OP_MUL:                        w_fix_res = w_prod[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:               w_fix_res = fix32(r_dvd, r_neg_res);
         default:                       w_fix_res = fix32(r_rem[XLEN-1:0], r_neg_rem);
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            w_next = S_IDLE;
            if (w_accept) begin
               if (w_special)    w_next = S_DONE;
               else if (i_op[2]) w_next = S_DIV_IT;
               else              w_next = S_MUL_IT;
            end
         end
         S_MUL_IT, S_DIV_IT: if (r_cnt == 5'(MDU_ITERS - 1)) w_next = S_FIX;
         S_FIX:              w_next = S_DONE;
         default:            w_next = S_IDLE;
      endcase
      if (i_kill) w_next = S_IDLE;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_result <= '0;
      end else begin
         r_state <= w_next;
         if (w_accept)
            r_cnt <= '0;
         else if (w_iter && !i_kill)
            r_cnt <= r_cnt + 5'd1;
         if (w_accept && w_special)
            r_result <= w_spec_res;
         else if ((r_state == S_FIX) && !i_kill)
            r_result <= w_fix_res;
      end
   end

   // Datapath registers carry no reset; they are loaded on every accept.
   always_ff @(posedge i_clk) begin
      if (w_accept) begin
         r_op      <= w_op;
         r_neg_res <= w_neg_a ^ w_neg_b;
         r_neg_rem <= w_neg_a;
         r_acc     <= '0;
         r_mcand   <= {{XLEN{1'b0}}, w_abs_a};
         r_mplier  <= w_abs_b;
         r_dvd     <= w_abs_a;
         r_dvs     <= w_abs_b;
         r_rem     <= '0;
      end else if (r_state == S_MUL_IT) begin
         if (r_mplier[0]) r_acc <= r_acc + r_mcand;
         r_mcand  <= r_mcand << 1;
         r_mplier <= r_mplier >> 1;
      end else if (r_state == S_DIV_IT) begin
         r_rem <= w_step_rem;
         r_dvd <= {r_dvd[XLEN-2:0], w_qbit};
      end
   end

   assign o_busy   = (r_state == S_MUL_IT) || (r_state == S_DIV_IT) || (r_state == S_FIX);
   assign o_done   = (r_state == S_DONE);
   assign o_result = r_result;

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: per-op latency, busy window, results, kill,
// ignored start, async reset and back-to-back issue.
`timescale 1ns/1ps
module tb_mdu;

   logic        i_clk = 1'b0;
   logic        i_rst_n = 1'b0;
   logic        i_start = 1'b0;
   logic [2:0]  i_op = 3'd0;
   logic [31:0] i_Ra = 32'd0;
   logic [31:0] i_Rb = 32'd0;
   logic        i_kill = 1'b0;
   logic        o_busy, o_done;
   logic [31:0] o_result;

   int n_checks = 0;
   int n_fail   = 0;

   mdu u_dut (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_start  (i_start),
      .i_op     (i_op),
      .i_Ra     (i_Ra),
      .i_Rb     (i_Rb),
      .i_kill   (i_kill),
      .o_busy   (o_busy),
      .o_done   (o_done),
      .o_result (o_result)
   );

   always #5 i_clk = ~i_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Drive a start pulse so that it is accepted on the next rising edge (edge k).
   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      @(negedge i_clk);
      i_start = 1'b1;
      i_op    = op;
      i_Ra    = a;
      i_Rb    = b;
      @(posedge i_clk);
   endtask

   // Observe cycles k+1..k+40 after an accept; optionally inject a start or a kill in one cycle.
   task automatic monitor(input string tag, input int exp_done, input int busy_last,
                          input logic [31:0] exp_res, input int inj_cycle, input logic inj_kill,
                          input logic [2:0] inj_op, input logic [31:0] inj_a, input logic [31:0] inj_b);
      int first_done = 0;
      int done_cnt   = 0;
      int busy_err   = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge i_clk);
         i_start = 1'b0;
         i_kill  = 1'b0;
         if (o_done === 1'b1) begin
            done_cnt++;
            if (first_done == 0) first_done = n;
         end
         if (o_busy !== (n <= busy_last)) busy_err++;
         if (n == inj_cycle) begin
            if (inj_kill) i_kill = 1'b1;
            else begin
               i_start = 1'b1;
               i_op    = inj_op;
               i_Ra    = inj_a;
               i_Rb    = inj_b;
            end
         end
      end
      check_eq({tag, " done_cycle"}, 32'(first_done), 32'(exp_done));
      check_eq({tag, " done_count"}, 32'(done_cnt), (exp_done > 0) ? 32'd1 : 32'd0);
      check_eq({tag, " busy_errs"},  32'(busy_err), 32'd0);
      check_eq({tag, " result"},     o_result, exp_res);
   endtask

   task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [31:0] exp_res, input logic special);
      issue(op, a, b);
      if (special) monitor(tag, 1, 0, exp_res, 0, 1'b0, 3'd0, 32'd0, 32'd0);
      else         monitor(tag, 34, 33, exp_res, 0, 1'b0, 3'd0, 32'd0, 32'd0);
   endtask

   initial begin
      #12;
      check_eq("rst busy",   {31'd0, o_busy}, 32'd0);
      check_eq("rst done",   {31'd0, o_done}, 32'd0);
      check_eq("rst result", o_result, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      run("MUL",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
      run("MULH",   3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1'b0);
      run("MULHU",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
      run("MULHSU", 3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
      run("DIV",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0);
      run("REM",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1'b0);
      run("DIVU",   3'd5, 32'd100,        32'd7,         32'd14,        1'b0);
      run("REMU",   3'd7, 32'd100,        32'd7,         32'd2,         1'b0);
      run("DIVU0",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1'b1);
      run("REM0",   3'd6, 32'd5,          32'd0,         32'd5,         1'b1);
      run("DIVOVF", 3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
      run("REMOVF", 3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1'b1);

      // Start while busy is ignored; DIV -7/2 still completes unchanged.
      issue(3'd4, 32'hFFFF_FFF9, 32'd2);
      monitor("IGNSTART", 34, 33, 32'hFFFF_FFFD, 5, 1'b0, 3'd0, 32'd3, 32'd3);

      // Kill at k+10: no done, result keeps the previous value.
      issue(3'd5, 32'd100, 32'd7);
      monitor("KILL", 0, 10, 32'hFFFF_FFFD, 10, 1'b1, 3'd0, 32'd0, 32'd0);

      // Asynchronous reset in cycle k+5 of a multiply.
      issue(3'd0, 32'd7, 32'hFFFF_FFFD);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (4) @(negedge i_clk);
      check_eq("pre-rst busy", {31'd0, o_busy}, 32'd1);
      i_rst_n = 1'b0;
      #1;
      check_eq("async rst busy",   {31'd0, o_busy}, 32'd0);
      check_eq("async rst done",   {31'd0, o_done}, 32'd0);
      check_eq("async rst result", o_result, 32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;

      // Back-to-back: DIVU 9/3 issued in the DONE cycle of a MUL.
      issue(3'd0, 32'd7, 32'hFFFF_FFFD);
      @(negedge i_clk);
      i_start = 1'b0;
      repeat (33) @(negedge i_clk);
      check_eq("B2B first done",   {31'd0, o_done}, 32'd1);
      check_eq("B2B first result", o_result, 32'hFFFF_FFEB);
      i_start = 1'b1;
      i_op    = 3'd5;
      i_Ra    = 32'd9;
      i_Rb    = 32'd3;
      @(posedge i_clk);
      monitor("B2B DIVU", 34, 33, 32'd3, 0, 1'b0, 3'd0, 32'd0, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
